// File: rtl/gpio_capture.sv
// GPIO byte sink: captures one byte per falling GPIOEn into a show-ahead FIFO
// with valid/ready output, frame byte counting, frame_done pulse and sticky overflow.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   GPIO, GPIOEn  processor byte and write strobe; a byte is committed when GPIOEn falls
//   out_*         FIFO head and valid/ready handshake
//   fifo_level    FIFO occupancy, 0..DEPTH
//   byte_count    strobes seen so far in the current frame
//   frame_active  high while a frame is in progress
//   frame_done    one-cycle pulse after the last byte of a frame
//   overflow      sticky flag, set when a byte was dropped because the FIFO was full
module gpio_capture #(
  parameter int DEPTH       = 16,
  parameter int FRAME_BYTES = 152100,
  parameter int CNT_W       = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 GPIO,
  input  logic                       GPIOEn,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           byte_count,
  output logic                       frame_active,
  output logic                       frame_done,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CNT_W:0] FB = (CNT_W+1)'(FRAME_BYTES);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state;
  logic            en_q;
  logic [7:0]      gpio_q;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            strobe;
  logic            full;
  logic            pop;
  logic            push;
  logic [CNT_W:0]  cnt_nxt;

  // Same clock domain as the processor, so no synchronizer is needed.
  assign strobe    = en_q & ~GPIOEn;
  assign full      = (level == LW'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still takes the byte when a slot frees up the same cycle.
  assign push      = strobe & (~full | pop);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_level   = level;
  assign frame_active = (state == ACTIVE);
  assign cnt_nxt   = {1'b0, byte_count} + (CNT_W+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      gpio_q <= 8'h00;
    end else begin
      en_q <= GPIOEn;
      if (GPIOEn) gpio_q <= GPIO;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gpio_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (strobe & full & ~pop) overflow <= 1'b1;
    end
  end

  // byte_count is always 0 in IDLE, so the entering strobe counts as byte 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_count <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (strobe) begin
        if (cnt_nxt == FB) begin
          state      <= IDLE;
          byte_count <= '0;
          frame_done <= 1'b1;
        end else begin
          state      <= ACTIVE;
          byte_count <= cnt_nxt[CNT_W-1:0];
        end
      end
    end
  end

endmodule

// File: doc/gpio_capture.md
# gpio_capture

Receive-side sink for the processor's 8-bit GPIO output port. Each high-to-low transition of `GPIOEn` marks one valid byte on `GPIO`. The block captures that byte into a small show-ahead FIFO and presents it downstream through a valid/ready handshake, for example to a UART transmitter or a host bridge. It also counts bytes against a fixed frame size (390×390 image, 152100 bytes), and reports frame completion and data loss.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `FRAME_BYTES`, 152100, bytes per frame.
- `CNT_W`, 18, width of `byte_count`; must hold `FRAME_BYTES-1`.

- `clk` in 1: single clock, shared with the processor.
- `rst` in 1: reset, asynchronous, active-high.
- `GPIO` in 8: byte driven by the processor; held stable while `GPIOEn`=1.
- `GPIOEn` in 1: write strobe from the processor; the byte is committed on its falling edge.
- `out_data` out 8: FIFO head byte.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: downstream accepts `out_data` this cycle.
- `fifo_level` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `byte_count` out CNT_W: strobes seen in the current frame.
- `frame_active` out 1: FSM is in ACTIVE.
- `frame_done` out 1: one-cycle pulse after the last byte of a frame.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.

## Operation
- **Input sampling**
  - `en_q` <= `GPIOEn` every cycle.
  - `gpio_q` <= `GPIO` on every cycle where `GPIOEn`=1; otherwise it holds.
- **Strobe detection:** strobe = `en_q` & ~`GPIOEn`. The byte written is `gpio_q`, the last value sampled while the enable was high. No synchronizer is used, because the processor is on the same clock.
- **FIFO:** circular buffer with read/write pointers of $clog2(DEPTH) bits plus a level counter.
  - Push on strobe.
  - Pop on `out_valid` & `out_ready`.
  - `out_data` = mem[rd_ptr]; its value is don't-care when empty.
  - Pointers wrap modulo DEPTH.
- **Simultaneous push and pop**
  - Empty: push only; a pop cannot occur because `out_valid`=0.
  - Full: the push is accepted because a slot frees the same cycle; level stays DEPTH and `overflow` is not set.
  - Otherwise: level is unchanged and both pointers advance.
- **Full with no pop:** the byte is dropped, `overflow` is set and stays set until reset, and `byte_count` still increments.
- **FSM**
  - IDLE → ACTIVE on the first strobe. That strobe counts, so `byte_count` becomes 1.
  - In ACTIVE, each strobe does `byte_count`+1.
  - On the strobe that would make `byte_count`==FRAME_BYTES: `byte_count`<=0, `frame_done` pulses, and the FSM returns to IDLE.
  - A strobe in IDLE always enters ACTIVE. Back-to-back frames therefore need no gap.
- **Reset** (any time, including mid-burst or mid-frame):
  - FIFO is emptied and buffered bytes are lost.
  - `en_q`=0 and `gpio_q`=0.
  - All outputs are 0: `out_valid`, `fifo_level`, `byte_count`, `frame_active`, `frame_done`, `overflow`. `out_data` is 0 when empty after reset.
  - If `GPIOEn` is high across reset release, the fall that follows still produces a byte, taken from data sampled after release.

## Timing
- Let edge E be the first rising edge at which `GPIOEn` is sampled 0 after ≥1 edge at 1.
  - The byte is written at E.
  - If the FIFO was empty, `out_valid`=1 and `out_data` is valid in the cycle after E. Latency is one cycle from the falling strobe.
- Minimum strobe: `GPIOEn` high for 1 edge and low for 1 edge, giving a peak rate of one byte per 2 cycles. A continuously high `GPIOEn` produces no bytes.
- Pop:
  - When `out_ready` is sampled 1 with `out_valid`=1 at edge P, the next entry or empty status is visible after P.
  - `out_ready` may be held high permanently.
  - `out_data` must not change while `out_valid`=1 and `out_ready`=0.
- `fifo_level`, `byte_count`, `frame_active` and `overflow` update at the same edge as the event that causes them.
- `frame_done` is high for exactly the one cycle after the final strobe edge.

## Test plan
- **Single byte:** reset, then `GPIO`=8'hA5 with `GPIOEn` 1 for 3 cycles, then 0, `out_ready`=0 → one cycle after the fall: `out_valid`=1, `out_data`=A5, `fifo_level`=1, `byte_count`=1, `frame_active`=1. Raising `out_ready` for one cycle → `out_valid`=0, level 0.
- **Ordering:** 20 strobes of bytes 0x00..0x13 at the peak rate with `out_ready`=1 → the sink receives 0x00..0x13 in order, no gaps, and `overflow`=0.
- **Overflow:** `out_ready`=0, 17 strobes of bytes 1..17 with DEPTH=16 → level 16, `overflow`=1, `byte_count`=17. Draining yields 1..16 only.
- **Full push+pop:** FIFO full and `out_ready`=1 in the same cycle as a strobe of 0x77 → level stays 16, `overflow` stays 0, and 0x77 is the last byte drained.
- **Frame boundary:** FRAME_BYTES=4 override, 9 strobes → `frame_done` pulses exactly after strobes 4 and 8, `byte_count` sequence is 1,2,3,0,1,2,3,0,1, and `frame_active` is 1 at the end.
- **Mid-operation reset:** 5 bytes buffered and `byte_count`=5, assert `rst` asynchronously between edges → all outputs go to 0 immediately. A following strobe of 0x3C gives `out_data`=3C and `byte_count`=1.
